// File: rtl/layer_neuron_engine.sv
// rtl/layer_neuron_engine.sv - per-layer neuron MAC engine: stream, accumulate, bias, saturate, hold done
// Define NEURON_RELU_EN to clamp negative results to zero.
module layer_neuron_engine #(
  parameter  int NUM_INPUTS = 784,
  parameter  int DATA_W     = 8,
  parameter  int WEIGHT_W   = 8,
  parameter  int ACC_W      = 32,
  parameter  int OUT_W      = 16,
  localparam int ADDR_W     = $clog2(NUM_INPUTS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_layer_en,
  input  logic                       i_in_valid,
  input  logic [DATA_W-1:0]          i_in_data,
  output logic                       o_in_ready,
  output logic [ADDR_W-1:0]          o_w_addr,
  input  logic signed [WEIGHT_W-1:0] i_w_data,
  input  logic signed [ACC_W-1:0]    i_bias,
  output logic                       o_out_valid,
  output logic signed [OUT_W-1:0]    o_out_data,
  input  logic                       i_out_ready,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int PROD_W = DATA_W + WEIGHT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_BIAS,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ADDR_W-1:0]          r_count;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [PROD_W-1:0]   r_prod_r;
  logic                       r_prod_v;
  logic                       w_clear;
  logic                       w_accept;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_acc_inc;
  logic signed [OUT_W-1:0]    w_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping layer_en anywhere before DONE aborts; in_ready/out_valid are gated so nothing transfers that cycle.
  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear = 1'b1;
        if (i_layer_en) w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        if (!i_layer_en) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else begin
          o_in_ready = 1'b1;
          if (i_in_valid && (r_count == LAST_IDX)) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!i_layer_en) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else begin
          w_state_next = S_BIAS;
        end
      end
      S_BIAS: begin
        if (!i_layer_en) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else begin
          w_state_next = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (!i_layer_en) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else begin
          o_out_valid = 1'b1;
          if (i_out_ready) w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!i_layer_en) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept  = i_in_valid && o_in_ready;
  assign w_prod    = PROD_W'($signed({1'b0, i_in_data})) * PROD_W'(i_w_data);
  assign w_acc_inc = (r_prod_v ? ACC_W'(r_prod_r) : '0) + ((r_state == S_BIAS) ? i_bias : '0);

  // The registered product lands in the accumulator one edge after its accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_prod_r <= '0;
      r_prod_v <= 1'b0;
    end else if (w_clear) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_prod_v <= 1'b0;
    end else begin
      r_prod_v <= w_accept;
      r_acc    <= r_acc + w_acc_inc;
      if (w_accept) begin
        r_prod_r <= w_prod;
        r_count  <= r_count + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    if (r_acc > SAT_MAX) begin
      w_sat = SAT_MAX[OUT_W-1:0];
    end else if (r_acc < SAT_MIN) begin
      w_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      w_sat = r_acc[OUT_W-1:0];
    end
`ifdef NEURON_RELU_EN
    if (r_acc[ACC_W-1]) w_sat = '0;
`endif
  end

  assign o_out_data = o_out_valid ? w_sat : '0;
  assign o_w_addr   = r_count;
  assign o_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_layer_neuron_engine.sv
// tb/tb_layer_neuron_engine.sv - directed-vector bench for layer_neuron_engine with NUM_INPUTS=4
module tb_layer_neuron_engine;

  localparam int N = 4;
`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        layer_en  = 1'b0;
  logic        in_valid  = 1'b0;
  logic [7:0]  in_data   = '0;
  logic        in_ready;
  logic [1:0]  w_addr;
  logic [7:0]  w_data;
  logic [31:0] bias      = '0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        done;

  logic [7:0]  dat [N];
  logic [7:0]  wts [N];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;
  assign w_data = wts[w_addr];

  layer_neuron_engine #(.NUM_INPUTS(N)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_layer_en  (layer_en),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_w_addr    (w_addr),
    .i_w_data    (w_data),
    .i_bias      (bias),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic load(input logic [7:0] d0, d1, d2, d3,
                      input logic [7:0] w0, w1, w2, w3, input logic [31:0] b);
    dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
    wts[0] = w0; wts[1] = w1; wts[2] = w2; wts[3] = w3;
    bias = b;
  endtask

  // Accept decision is observed just before the posedge that performs it.
  task automatic feed(input int n, input bit toggle, input string tag);
    int i = 0;
    int cyc = 0;
    while (i < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (toggle) chk({tag, "_addr"}, {30'd0, w_addr}, 32'(i));
      in_valid = toggle ? cyc[0] : 1'b1;
      in_data  = dat[i];
      #1;
      if (in_valid && in_ready) i++;
    end
    if (i < n) chk({tag, "_feed_timeout"}, 32'(i), 32'(n));
  endtask

  task automatic run(input logic [15:0] exp, input bit toggle, input int stall, input string tag);
    layer_en = 1'b1;
    feed(N, toggle, tag);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_lat2_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk({tag, "_lat3_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_data"}, {16'd0, out_data}, {16'd0, exp});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic release_en(input string tag);
    layer_en = 1'b0;
    @(negedge clk);
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_w_addr"}, {30'd0, w_addr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    load(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 32'd0);
    run(16'd10, 1'b0, 0, "basic");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rearm_done", {31'd0, done}, 32'd1);
      chk("rearm_busy", {31'd0, busy}, 32'd0);
    end
    release_en("basic");

    load(8'd10, 8'd10, 8'd10, 8'd10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'd0);
    run(RELU ? 16'h0000 : 16'hFFD8, 1'b0, 0, "negative");
    release_en("negative");

    load(8'd255, 8'd255, 8'd255, 8'd255, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 32'd100000);
    run(16'h7FFF, 1'b0, 0, "sat_hi");
    release_en("sat_hi");

    load(8'd255, 8'd255, 8'd255, 8'd255, 8'h80, 8'h80, 8'h80, 8'h80, 32'hFFFE7960);
    run(RELU ? 16'h0000 : 16'h8000, 1'b0, 0, "sat_lo");
    release_en("sat_lo");

    load(8'd5, 8'd6, 8'd7, 8'd8, 8'h01, 8'hFE, 8'h03, 8'hFC, 32'd50);
    run(16'h0020, 1'b1, 4, "backpressure");
    release_en("backpressure");

    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 32'd0);
    layer_en = 1'b1;
    feed(2, 1'b0, "abort");
    @(negedge clk);
    chk("abort_addr_before", {30'd0, w_addr}, 32'd2);
    layer_en = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'd9;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_addr", {30'd0, w_addr}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    load(8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 32'd0);
    run(16'd8, 1'b0, 0, "rearm");
    release_en("rearm");

    load(8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd1, 8'd1, 8'd1, 32'd0);
    layer_en = 1'b1;
    feed(2, 1'b0, "rst");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    in_valid = 1'b0;
    layer_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(16'd10, 1'b0, 0, "post_rst");
    release_en("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
